if_fetch_ctrl: RTL and testbench



---
 rtl/if_pkg.sv | 14 +
 rtl/if_fetch_ctrl_if.sv | 24 ++
 rtl/fetch_inst_buf.sv | 34 +++
 rtl/if_fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared constants for the instruction-fetch front end
package if_pkg;

    localparam logic [1:0]  REQ            = 2'b01;
    localparam logic [1:0]  WAIT           = 2'b10;
    localparam logic [31:0] RESET_PC_DEF   = 32'h1c00_0000;
    localparam logic [31:0] NOP_INST       = 32'h0340_0000;
    localparam logic [1:0]  INST_SIZE_WORD = 2'b10;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: SRAM-like instruction port between fetch and the AXI bridge
interface if_fetch_ctrl_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/fetch_inst_buf.sv
// fetch_inst_buf: one-entry instruction buffer between IF and ID
module fetch_inst_buf (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        load,
    input  logic        drain,
    input  logic        inval,
    input  logic [31:0] ld_pc,
    input  logic [31:0] ld_inst,
    input  logic        ld_ex,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        ex
);

    // invalidate beats a refill, a refill beats a drain
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            inst  <= 32'h0;
            ex    <= 1'b0;
        end else begin
            valid <= inval ? 1'b0 : load ? 1'b1 : drain ? 1'b0 : valid;
            if (load && !inval) begin
                pc   <= ld_pc;
                inst <= ld_inst;
                ex   <= ld_ex;
            end
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: pre-IF/IF fetch controller; FETCH_ADEF_CHECK_EN enables misaligned-PC ADEF entries
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        id_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_ex_adef,
    if_fetch_ctrl_if.master sram
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        held;
    logic        discard;
    logic        disc_pend;
    logic        redir;
    logic [31:0] redir_pc;
    logic        buf_free;
    logic        in_req;
    logic        in_wait;
    logic        misalign;
    logic        adef_load;
    logic        accept;

    assign redir    = flush | br_taken;
    assign redir_pc = flush ? flush_pc : br_target;
    assign buf_free = !fs_to_ds_valid | id_allowin;
    assign in_req   = state == REQ;
    assign in_wait  = state == WAIT;
    assign accept   = in_wait & sram.data_ok & !discard & !redir;

`ifdef FETCH_ADEF_CHECK_EN
    logic adef_stall;
    assign misalign  = pc[1:0] != 2'b00;
    assign adef_load = in_req & misalign & buf_free & !adef_stall & !redir;

    // a misaligned PC loads one ADEF entry, then fetch waits for a redirect
    always_ff @(posedge aclk) begin
        if (!aresetn)
            adef_stall <= 1'b0;
        else if (redir)
            adef_stall <= 1'b0;
        else if (adef_load)
            adef_stall <= 1'b1;
    end
`else
    assign misalign  = 1'b0;
    assign adef_load = 1'b0;
`endif

    // an issued request is held with a fixed address until the bridge accepts it
    assign sram.req   = in_req & (held | (buf_free & !misalign));
    assign sram.addr  = pc;
    assign sram.wr    = 1'b0;
    assign sram.size  = INST_SIZE_WORD;
    assign sram.wstrb = 4'h0;
    assign sram.wdata = 32'h0;

    // fetch FSM: redirects during an in-flight fetch park the target in tgt and mark it for discard
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= REQ;
            pc        <= RESET_PC;
            tgt       <= RESET_PC;
            held      <= 1'b0;
            discard   <= 1'b0;
            disc_pend <= 1'b0;
        end else if (in_req) begin
            if (sram.req && sram.addr_ok) begin
                state     <= WAIT;
                held      <= 1'b0;
                discard   <= redir | disc_pend;
                disc_pend <= 1'b0;
                if (redir)
                    tgt <= redir_pc;
            end else if (sram.req) begin
                held <= 1'b1;
                if (redir) begin
                    disc_pend <= 1'b1;
                    tgt       <= redir_pc;
                end
            end else if (redir) begin
                pc <= redir_pc;
            end
        end else if (sram.data_ok) begin
            state   <= REQ;
            discard <= 1'b0;
            pc      <= accept ? pc_next(pc) : redir ? redir_pc : tgt;
        end else if (redir) begin
            discard <= 1'b1;
            tgt     <= redir_pc;
        end
    end

    fetch_inst_buf u_buf (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (accept | adef_load),
        .drain   (id_allowin),
        .inval   (redir),
        .ld_pc   (pc),
        .ld_inst (adef_load ? NOP_INST : sram.rdata),
        .ld_ex   (adef_load),
        .valid   (fs_to_ds_valid),
        .pc      (fs_pc),
        .inst    (fs_inst),
        .ex      (fs_ex_adef)
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    logic        aclk;
    logic        aresetn;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        id_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_ex_adef;
    int          errors;
    int          checks;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .id_allowin     (id_allowin),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_pc          (fs_pc),
        .fs_inst        (fs_inst),
        .fs_ex_adef     (fs_ex_adef),
        .sram           (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one cycle, then drive this cycle's inputs with redirects cleared
    task automatic drv(input logic al, input logic aok, input logic dok, input logic [31:0] rd);
        @(posedge aclk);
        #1;
        id_allowin   = al;
        bus.addr_ok  = aok;
        bus.data_ok  = dok;
        bus.rdata    = rd;
        br_taken     = 1'b0;
        flush        = 1'b0;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        aresetn = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;
        flush = 1'b0;
        flush_pc = 32'h0;
        id_allowin = 1'b1;
        bus.addr_ok = 1'b0;
        bus.data_ok = 1'b0;
        bus.rdata = 32'h0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_valid", fs_to_ds_valid, 0);
        chk("rst_pc", fs_pc, 0);
        chk("rst_inst", fs_inst, 0);
        chk("rst_adef", fs_ex_adef, 0);

        aresetn = 1'b1;
        bus.addr_ok = 1'b1;
        #1;
        chk("first_req", bus.req, 1);
        chk("first_addr", bus.addr, 32'h1c00_0000);
        chk("tie_wr", bus.wr, 0);
        chk("tie_size", bus.size, 2);
        chk("tie_wstrb", bus.wstrb, 0);
        chk("tie_wdata", bus.wdata, 0);
        drv(1, 0, 1, 32'h1111_0000);
        chk("wait_noreq", bus.req, 0);
        drv(1, 1, 0, 0);
        chk("f0_valid", fs_to_ds_valid, 1);
        chk("f0_pc", fs_pc, 32'h1c00_0000);
        chk("f0_inst", fs_inst, 32'h1111_0000);
        chk("f1_req", bus.req, 1);
        chk("f1_addr", bus.addr, 32'h1c00_0004);
        drv(1, 0, 1, 32'h1111_0004);
        chk("drained", fs_to_ds_valid, 0);
        drv(1, 1, 0, 0);
        chk("f1_pc", fs_pc, 32'h1c00_0004);
        chk("f1_inst", fs_inst, 32'h1111_0004);
        chk("f2_addr", bus.addr, 32'h1c00_0008);
        drv(1, 0, 1, 32'h1111_0008);
        drv(1, 0, 0, 0);
        chk("f2_valid", fs_to_ds_valid, 1);
        chk("f2_pc", fs_pc, 32'h1c00_0008);
        chk("f2_inst", fs_inst, 32'h1111_0008);
        chk("f3_addr", bus.addr, 32'h1c00_000c);

        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        chk("mid_rst_valid", fs_to_ds_valid, 0);
        chk("mid_rst_pc", fs_pc, 0);
        aresetn = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h1c00_0100;
        #1;
        chk("hold_req0", bus.req, 1);
        chk("hold_addr0", bus.addr, 32'h1c00_0000);
        drv(1, 0, 0, 0);
        chk("hold_req1", bus.req, 1);
        chk("hold_addr1", bus.addr, 32'h1c00_0000);
        drv(1, 0, 0, 0);
        chk("hold_req2", bus.req, 1);
        chk("hold_addr2", bus.addr, 32'h1c00_0000);
        drv(1, 1, 0, 0);
        chk("hold_req3", bus.req, 1);
        chk("hold_addr3", bus.addr, 32'h1c00_0000);
        drv(1, 0, 1, 32'hdead_0001);
        chk("disc_wait_req", bus.req, 0);
        drv(1, 1, 0, 0);
        chk("disc_valid", fs_to_ds_valid, 0);
        chk("br_req", bus.req, 1);
        chk("br_addr", bus.addr, 32'h1c00_0100);
        drv(1, 0, 1, 32'h2222_0100);
        drv(1, 1, 0, 0);
        chk("br_pc", fs_pc, 32'h1c00_0100);
        chk("br_inst", fs_inst, 32'h2222_0100);
        chk("br_next", bus.addr, 32'h1c00_0104);

        drv(1, 0, 0, 0);
        flush = 1'b1;
        flush_pc = 32'h1c00_8000;
        br_taken = 1'b1;
        br_target = 32'h1c00_0200;
        chk("fl_wait_req", bus.req, 0);
        drv(1, 0, 1, 32'hdead_0002);
        chk("fl_drop_valid", fs_to_ds_valid, 0);
        drv(1, 1, 0, 0);
        chk("fl_valid", fs_to_ds_valid, 0);
        chk("fl_req", bus.req, 1);
        chk("fl_addr", bus.addr, 32'h1c00_8000);

        drv(1, 0, 1, 32'hdead_0003);
        br_taken = 1'b1;
        br_target = 32'h1c00_0300;
        drv(1, 1, 0, 0);
        chk("dok_br_valid", fs_to_ds_valid, 0);
        chk("dok_br_req", bus.req, 1);
        chk("dok_br_addr", bus.addr, 32'h1c00_0300);
        drv(1, 0, 1, 32'h3333_0300);
        drv(0, 0, 0, 0);
        chk("dok_br_pc", fs_pc, 32'h1c00_0300);
        chk("dok_br_inst", fs_inst, 32'h3333_0300);

        chk("stall_req", bus.req, 0);
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 0);
            chk("stall_req", bus.req, 0);
            chk("stall_valid", fs_to_ds_valid, 1);
            chk("stall_pc", fs_pc, 32'h1c00_0300);
            chk("stall_inst", fs_inst, 32'h3333_0300);
        end
        drv(1, 1, 0, 0);
        chk("resume_req", bus.req, 1);
        chk("resume_addr", bus.addr, 32'h1c00_0304);
        drv(1, 0, 1, 32'h4444_0304);
        drv(0, 0, 0, 0);
        chk("resume_pc", fs_pc, 32'h1c00_0304);
        chk("resume_inst", fs_inst, 32'h4444_0304);

        chk("idle_br_req", bus.req, 0);
        br_taken = 1'b1;
        br_target = 32'h1c00_0400;
        drv(1, 1, 0, 0);
        chk("idle_br_valid", fs_to_ds_valid, 0);
        chk("idle_br_req1", bus.req, 1);
        chk("idle_br_addr", bus.addr, 32'h1c00_0400);
        drv(1, 0, 1, 32'h5555_0400);
        drv(0, 0, 0, 0);
        chk("idle_br_pc", fs_pc, 32'h1c00_0400);
        chk("idle_br_inst", fs_inst, 32'h5555_0400);

        br_taken = 1'b1;
        br_target = 32'hffff_fffc;
        drv(1, 1, 0, 0);
        chk("wrap_addr0", bus.addr, 32'hffff_fffc);
        drv(1, 0, 1, 32'h6666_fffc);
        drv(0, 0, 0, 0);
        chk("wrap_pc", fs_pc, 32'hffff_fffc);
        chk("wrap_inst", fs_inst, 32'h6666_fffc);
        chk("wrap_addr", bus.addr, 32'h0);

        flush = 1'b1;
        flush_pc = 32'h1c00_0002;
`ifdef FETCH_ADEF_CHECK_EN
        drv(1, 0, 0, 0);
        chk("adef_noreq", bus.req, 0);
        chk("adef_pre_valid", fs_to_ds_valid, 0);
        drv(1, 0, 0, 0);
        chk("adef_valid", fs_to_ds_valid, 1);
        chk("adef_ex", fs_ex_adef, 1);
        chk("adef_pc", fs_pc, 32'h1c00_0002);
        chk("adef_inst", fs_inst, 32'h0340_0000);
        chk("adef_req", bus.req, 0);
        drv(1, 0, 0, 0);
        chk("adef_drained", fs_to_ds_valid, 0);
        chk("adef_stall", bus.req, 0);
        flush = 1'b1;
        flush_pc = 32'h1c00_0000;
        drv(1, 1, 0, 0);
        chk("adef_res_req", bus.req, 1);
        chk("adef_res_addr", bus.addr, 32'h1c00_0000);
        drv(1, 0, 1, 32'h7777_0000);
        drv(1, 0, 0, 0);
        chk("adef_res_valid", fs_to_ds_valid, 1);
        chk("adef_res_ex", fs_ex_adef, 0);
        chk("adef_res_pc", fs_pc, 32'h1c00_0000);
        chk("adef_res_inst", fs_inst, 32'h7777_0000);
`else
        drv(1, 1, 0, 0);
        chk("mis_req", bus.req, 1);
        chk("mis_addr", bus.addr, 32'h1c00_0002);
        drv(1, 0, 1, 32'h7777_0002);
        drv(1, 0, 0, 0);
        chk("mis_valid", fs_to_ds_valid, 1);
        chk("mis_pc", fs_pc, 32'h1c00_0002);
        chk("mis_inst", fs_inst, 32'h7777_0002);
        chk("mis_ex", fs_ex_adef, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
